// File: rtl/plic_lite_pkg.sv
// Shared register map, ID width and the external-interrupt marker for plic_lite.
package plic_lite_pkg;

  localparam logic [7:0] PLIC_PENDING   = 8'h00;
  localparam logic [7:0] PLIC_ENABLE    = 8'h04;
  localparam logic [7:0] PLIC_THRESH    = 8'h08;
  localparam logic [7:0] PLIC_CLAIM     = 8'h0C;
  localparam logic [7:0] PLIC_PRIO_BASE = 8'h10;

  localparam int unsigned INT_EXT_FLAG = 7;
  localparam int unsigned ID_W         = 4;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: 2-flop synchronizer, rising-edge detect, pending and in-service bits.
module plic_gateway (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic sync1_q, sync2_q, sync3_q;
  logic arm1_q, arm2_q, arm3_q;
  logic pending_q, in_service_q;
  logic rise;

  // A line already high when reset releases must not look like an edge, so detection
  // waits until sync3 holds a real sample.
  assign rise = sync2_q & ~sync3_q & arm3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      arm1_q       <= 1'b0;
      arm2_q       <= 1'b0;
      arm3_q       <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      arm1_q  <= 1'b1;
      arm2_q  <= arm1_q;
      arm3_q  <= arm2_q;
      // A new edge in the same cycle as a claim keeps the event pending.
      if (rise) begin
        pending_q <= 1'b1;
      end else if (claim) begin
        pending_q <= 1'b0;
      end
      if (claim) begin
        in_service_q <= 1'b1;
      end else if (complete) begin
        in_service_q <= 1'b0;
      end
    end
  end

  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: rtl/plic_lite.sv
// Lite PLIC: per-source gateways, priority/threshold arbitration and a claim/complete
// register interface; the winner is presented to clint on int_flag_o.
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               irq_o,
  output logic [7:0]         int_flag_o
);

  localparam logic [5:0] NumSrc6 = 6'(NUM_SRC);

  logic [NUM_SRC-1:0] enable_q;
  logic [PRIO_W-1:0]  thresh_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [ID_W-1:0]    best_id_q, best_id_d;
  logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
  logic               irq_q;

  logic [NUM_SRC-1:0] pending, in_service, eligible;
  logic [NUM_SRC-1:0] claim_vec, cmpl_vec;

  logic [7:0]      offs, prio_rel;
  logic            prio_hit, claim_hit, cmpl_hit;
  logic [ID_W-1:0] prio_idx, cmpl_id;

  assign offs     = addr_i[7:0];
  assign prio_rel = offs - PLIC_PRIO_BASE;
  assign prio_hit = (offs >= PLIC_PRIO_BASE) && (prio_rel[1:0] == 2'b00) &&
                    (prio_rel[7:2] < NumSrc6);
  assign prio_idx = prio_rel[5:2];

  assign claim_hit = re_i && (offs == PLIC_CLAIM) && (best_id_q != '0);
  assign cmpl_hit  = we_i && (offs == PLIC_CLAIM);
  assign cmpl_id   = data_i[ID_W-1:0];

  always_comb begin
    claim_vec = '0;
    cmpl_vec  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i] = claim_hit && (best_id_q == ID_W'(i + 1));
      cmpl_vec[i]  = cmpl_hit && (cmpl_id == ID_W'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    plic_gateway u_gateway (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq_i[g]),
      .claim      (claim_vec[g]),
      .complete   (cmpl_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
    assign eligible[g] = pending[g] & enable_q[g] & ~in_service[g] & (prio_q[g] > thresh_q);
  end

  // Strict '>' against a running max makes ties resolve to the lowest ID.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (prio_q[i] > best_prio_d)) begin
        best_id_d   = ID_W'(i + 1);
        best_prio_d = prio_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= '0;
      thresh_q    <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_q[i] <= '0;
      end
    end else begin
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      irq_q       <= (best_id_d != '0);
      if (we_i && (offs == PLIC_ENABLE)) begin
        enable_q <= data_i[NUM_SRC-1:0];
      end
      if (we_i && (offs == PLIC_THRESH)) begin
        thresh_q <= data_i[PRIO_W-1:0];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (we_i && prio_hit && (prio_idx == ID_W'(i))) begin
          prio_q[i] <= data_i[PRIO_W-1:0];
        end
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (offs == PLIC_PENDING) begin
      data_o[NUM_SRC-1:0] = pending;
    end else if (offs == PLIC_ENABLE) begin
      data_o[NUM_SRC-1:0] = enable_q;
    end else if (offs == PLIC_THRESH) begin
      data_o[PRIO_W-1:0] = thresh_q;
    end else if (offs == PLIC_CLAIM) begin
      data_o[ID_W-1:0] = best_id_q;
    end else if (prio_hit) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (prio_idx == ID_W'(i)) begin
          data_o[PRIO_W-1:0] = prio_q[i];
        end
      end
    end
  end

  always_comb begin
    int_flag_o = 8'h00;
    if (irq_q) begin
      int_flag_o[ID_W-1:0]     = best_id_q;
      int_flag_o[INT_EXT_FLAG] = 1'b1;
    end
  end

  assign irq_o = irq_q;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i[31:8], best_prio_q};

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: gateway latency, arbitration, threshold, claim/complete, reset.
module tb_plic_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i;
  logic        we_i, re_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        irq_o;
  logic [7:0]  int_flag_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] APend  = 32'h00;
  localparam logic [31:0] AEn    = 32'h04;
  localparam logic [31:0] AThr   = 32'h08;
  localparam logic [31:0] AClaim = 32'h0C;

  plic_lite #(
    .NUM_SRC (8),
    .PRIO_W  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .irq_o      (irq_o),
    .int_flag_o (int_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    re_i = 1'b1; addr_i = a;
    @(negedge clk);
    d = data_o;
    @(posedge clk);
    #1;
    re_i = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; irq_i = '0; we_i = 1'b0; re_i = 1'b0; addr_i = '0; data_i = '0;
    cycles(3);
    rst = 1'b0;
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_flag", {24'b0, int_flag_o}, 32'd0);
    peek(APend, v); check("rst_pend", v, 32'd0);

    // 1: single source, latency and flag format
    wr(32'h18, 32'd5);
    wr(AEn, 32'h04);
    wr(AThr, 32'd0);
    peek(32'h18, v); check("prio3_rb", v, 32'd5);
    irq_i[2] = 1'b1;
    cycles(2);
    peek(APend, v); check("pend_2cyc", v, 32'd0);
    cycles(1);
    peek(APend, v); check("pend_3cyc", v, 32'h04);
    check("irq_3cyc", {31'b0, irq_o}, 32'd0);
    cycles(1);
    check("irq_4cyc", {31'b0, irq_o}, 32'd1);
    check("flag_src3", {24'b0, int_flag_o}, 32'h83);
    rd(AClaim, v); check("claim3", v, 32'd3);
    irq_i[2] = 1'b0;
    cycles(2);
    check("irq_after_claim3", {31'b0, irq_o}, 32'd0);
    wr(AClaim, 32'd3);

    // 2: priority tie goes to lowest ID
    wr(32'h14, 32'd4);
    wr(32'h20, 32'd4);
    wr(AEn, 32'h12);
    irq_i[1] = 1'b1; irq_i[4] = 1'b1;
    cycles(5);
    irq_i[1] = 1'b0; irq_i[4] = 1'b0;
    check("flag_tie", {24'b0, int_flag_o}, 32'h82);
    rd(AClaim, v); check("claim_tie", v, 32'd2);
    cycles(2);
    rd(AClaim, v); check("claim_next", v, 32'd5);
    cycles(2);
    check("irq_both_in_svc", {31'b0, irq_o}, 32'd0);
    wr(AClaim, 32'd2);
    wr(AClaim, 32'd5);
    cycles(2);
    check("irq_after_cmpl", {31'b0, irq_o}, 32'd0);
    peek(APend, v); check("pend_after_cmpl", v, 32'd0);

    // 3: threshold is strict; write takes effect two cycles later
    wr(AThr, 32'd4);
    wr(32'h10, 32'hFFFF_FFFC);
    peek(32'h10, v); check("prio1_width", v, 32'd4);
    wr(AEn, 32'h01);
    irq_i[0] = 1'b1;
    cycles(5);
    irq_i[0] = 1'b0;
    peek(APend, v); check("pend_src1", v, 32'h01);
    check("irq_at_thresh", {31'b0, irq_o}, 32'd0);
    wr(AThr, 32'd3);
    check("irq_thr_wr_1", {31'b0, irq_o}, 32'd0);
    cycles(1);
    check("irq_thr_wr_2", {31'b0, irq_o}, 32'd1);

    // 4: edge while in service is held pending but ineligible
    rd(AClaim, v); check("claim1", v, 32'd1);
    irq_i[0] = 1'b1;
    cycles(5);
    irq_i[0] = 1'b0;
    peek(APend, v); check("pend_in_svc", v, 32'h01);
    check("irq_in_svc", {31'b0, irq_o}, 32'd0);
    wr(AClaim, 32'd1);
    check("irq_cmpl_edge", {31'b0, irq_o}, 32'd0);
    cycles(1);
    check("irq_cmpl_next", {31'b0, irq_o}, 32'd1);
    rd(AClaim, v); check("claim1_again", v, 32'd1);
    cycles(2);

    // 5: empty claim and bogus completes change nothing
    rd(AClaim, v); check("claim_empty", v, 32'd0);
    peek(APend, v); check("pend_empty", v, 32'd0);
    peek(AEn, v); check("en_keep", v, 32'h01);
    wr(AClaim, 32'd0);
    wr(AClaim, 32'd9);
    wr(AClaim, 32'd2);
    wr(APend, 32'hFF);
    wr(32'h80, 32'hFF);
    cycles(1);
    peek(APend, v); check("pend_ro", v, 32'd0);
    peek(32'h80, v); check("unmapped", v, 32'd0);
    peek(AThr, v); check("thr_keep", v, 32'd3);
    cycles(3);
    irq_i[0] = 1'b1;
    cycles(5);
    peek(APend, v); check("pend_still_svc", v, 32'h01);
    check("irq_still_svc", {31'b0, irq_o}, 32'd0);
    wr(AClaim, 32'd1);
    cycles(1);
    check("flag_src1", {24'b0, int_flag_o}, 32'h81);

    // 6: mid-operation reset with lines held high
    irq_i[1] = 1'b1; irq_i[4] = 1'b1;
    cycles(5);
    rd(AClaim, v); check("claim_pre_rst", v, 32'd1);
    cycles(1);
    peek(APend, v); check("pend_pre_rst", v, 32'h12);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mrst_irq", {31'b0, irq_o}, 32'd0);
    check("mrst_flag", {24'b0, int_flag_o}, 32'd0);
    peek(APend, v); check("mrst_pend", v, 32'd0);
    peek(AEn, v); check("mrst_en", v, 32'd0);
    peek(AThr, v); check("mrst_thr", v, 32'd0);
    peek(AClaim, v); check("mrst_claim", v, 32'd0);
    peek(32'h10, v); check("mrst_prio1", v, 32'd0);
    cycles(6);
    peek(APend, v); check("held_high_no_edge", v, 32'd0);
    check("held_high_irq", {31'b0, irq_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
